// File: rtl/slp_update_ctrl_pkg.sv
// rtl/slp_update_ctrl_pkg.sv - shared state encoding and helpers for the slp weight-update controller
package slp_update_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CALC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } slp_state_e;

    function automatic logic slp_is_busy(input slp_state_e s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/slp_update_ctrl_if.sv
// rtl/slp_update_ctrl_if.sv - shared input/weight memory port of the slp weight-update controller
interface slp_update_ctrl_if #(
    parameter int IDX_W  = 3,
    parameter int I_PREC = 8,
    parameter int W_PREC = 16
);
    logic [IDX_W-1:0]  mem_addr;
    logic              mem_re;
    logic [I_PREC-1:0] in_data;
    logic [W_PREC-1:0] w_rdata;
    logic              mem_we;
    logic [W_PREC-1:0] w_wdata;

    modport master (
        output mem_addr, mem_re, mem_we, w_wdata,
        input  in_data, w_rdata
    );

    modport slave (
        input  mem_addr, mem_re, mem_we, w_wdata,
        output in_data, w_rdata
    );
endinterface

// File: rtl/slp_update_ctrl_calc.sv
// rtl/slp_update_ctrl_calc.sv - combinational fixed-point weight update with saturation
module slp_calc_fp_weight #(
    parameter bit ADALINE = 1'b1,
    parameter int I_PREC  = 8,
    parameter int I_EXP   = 3,
    parameter int R_PREC  = 5,
    parameter int R_EXP   = 5,
    parameter int W_PREC  = 16,
    parameter int W_EXP   = 4,
    parameter int F_PREC  = 8,
    parameter int F_EXP   = 3
) (
    input  logic [I_PREC-1:0] i_in_data,
    input  logic [W_PREC-1:0] i_weight,
    input  logic [R_PREC-1:0] i_rate,
    input  logic [F_PREC-1:0] i_error,
    output logic [W_PREC-1:0] o_new_weight
);
    localparam int XW     = I_PREC + 1;
    localparam int PROD_W = R_PREC + 1 + F_PREC + XW;
    localparam int FRAC_P = R_EXP + F_EXP + I_EXP;
    localparam int SUM_W  = ((PROD_W + W_EXP > W_PREC) ? PROD_W + W_EXP : W_PREC) + 2;

    localparam logic signed [XW-1:0]    X_ONE = XW'(1 << I_EXP);
    localparam logic signed [SUM_W-1:0] W_MAX = {{(SUM_W-W_PREC+1){1'b0}}, {(W_PREC-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] W_MIN = {{(SUM_W-W_PREC+1){1'b1}}, {(W_PREC-1){1'b0}}};

    logic signed [XW-1:0]     w_x;
    logic signed [PROD_W-1:0] w_rate_e;
    logic signed [PROD_W-1:0] w_err_e;
    logic signed [PROD_W-1:0] w_x_e;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [SUM_W-1:0]  w_delta;
    logic signed [SUM_W-1:0]  w_sum;

    // Perceptron mode only uses the sign of each input, scaled to 1.0.
    generate
        if (ADALINE) begin : g_adaline
            assign w_x = {i_in_data[I_PREC-1], i_in_data};
        end else begin : g_perceptron
            assign w_x = i_in_data[I_PREC-1] ? -X_ONE : ((|i_in_data) ? X_ONE : '0);
        end
    endgenerate

    assign w_rate_e = PROD_W'({1'b0, i_rate});
    assign w_err_e  = PROD_W'($signed(i_error));
    assign w_x_e    = PROD_W'(w_x);
    assign w_prod   = w_rate_e * w_err_e * w_x_e;

    // Realign the product to the weight's binary point; right shifts floor.
    generate
        if (FRAC_P >= W_EXP) begin : g_shr
            assign w_delta = SUM_W'(w_prod) >>> (FRAC_P - W_EXP);
        end else begin : g_shl
            assign w_delta = SUM_W'(w_prod) <<< (W_EXP - FRAC_P);
        end
    endgenerate

    assign w_sum = w_delta + SUM_W'($signed(i_weight));

    always_comb begin
        if (w_sum > W_MAX) begin
            o_new_weight = {1'b0, {(W_PREC-1){1'b1}}};
        end else if (w_sum < W_MIN) begin
            o_new_weight = {1'b1, {(W_PREC-1){1'b0}}};
        end else begin
            o_new_weight = w_sum[W_PREC-1:0];
        end
    end

endmodule

// File: rtl/slp_update_ctrl.sv
// rtl/slp_update_ctrl.sv - sequences read/calc/write of every weight for one training update
module slp_update_ctrl
    import slp_update_ctrl_pkg::*;
#(
    parameter bit ADALINE = 1'b1,
    parameter int N_IN    = 8,
    parameter int I_PREC  = 8,
    parameter int I_EXP   = 3,
    parameter int R_PREC  = 5,
    parameter int R_EXP   = 5,
    parameter int W_PREC  = 16,
    parameter int W_EXP   = 4,
    parameter int F_PREC  = 8,
    parameter int F_EXP   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [R_PREC-1:0] rate,
    input  logic [F_PREC-1:0] error,
    output logic              busy,
    output logic              done,
    slp_update_ctrl_if.master mem
);
    localparam int IDX_W = $clog2(N_IN);

    slp_state_e        r_state;
    slp_state_e        w_next;
    logic [IDX_W-1:0]  r_idx;
    logic [R_PREC-1:0] r_rate;
    logic [F_PREC-1:0] r_error;
    logic [W_PREC-1:0] r_wdata;
    logic [W_PREC-1:0] w_new_weight;
    logic              w_last;

    assign w_last = (r_idx == IDX_W'(N_IN - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        busy         = slp_is_busy(r_state);
        done         = 1'b0;
        mem.mem_re   = 1'b0;
        mem.mem_we   = 1'b0;
        mem.mem_addr = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    // A zero error cannot move any weight, so skip the memory sweep.
                    w_next = (error == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                mem.mem_re   = 1'b1;
                mem.mem_addr = r_idx;
                w_next       = ST_CALC;
            end
            ST_CALC: begin
                w_next = ST_WRITE;
            end
            ST_WRITE: begin
                mem.mem_we   = 1'b1;
                mem.mem_addr = r_idx;
                w_next       = w_last ? ST_DONE : ST_READ;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx   <= '0;
            r_rate  <= '0;
            r_error <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rate  <= rate;
                        r_error <= error;
                        r_idx   <= '0;
                    end
                end
                ST_CALC: begin
                    r_wdata <= w_new_weight;
                end
                ST_WRITE: begin
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem.w_wdata = r_wdata;

    slp_calc_fp_weight #(
        .ADALINE (ADALINE),
        .I_PREC  (I_PREC),
        .I_EXP   (I_EXP),
        .R_PREC  (R_PREC),
        .R_EXP   (R_EXP),
        .W_PREC  (W_PREC),
        .W_EXP   (W_EXP),
        .F_PREC  (F_PREC),
        .F_EXP   (F_EXP)
    ) u_calc (
        .i_in_data    (mem.in_data),
        .i_weight     (mem.w_rdata),
        .i_rate       (r_rate),
        .i_error      (r_error),
        .o_new_weight (w_new_weight)
    );

endmodule

// File: doc/slp_update_ctrl.md
SLP_UPDATE_CTRL -- requirements
Module: slp_update_ctrl

Interface
REQ-001 Parameter ADALINE, default `Enable: learning scheme, passed unchanged to the weight-calc datapath.
REQ-002 Parameter N_IN, default 8: number of inputs and weights; legal range 2..256.
REQ-003 Parameters I_PREC/I_EXP (8/3), R_PREC/R_EXP (5/5), W_PREC/W_EXP (16/4), F_PREC/F_EXP (8/3): fixed-point formats, passed to the datapath.
REQ-004 Localparam IDX_W = $clog2(N_IN): address width.
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 Port clk, input, 1: clock, rising edge.
REQ-007 Port reset, input, 1: asynchronous, active-high reset.
REQ-008 Port start, input, 1: request one training update.
REQ-009 Port rate, input, R_PREC: learning rate, sampled when start is accepted.
REQ-010 Port error, input, F_PREC: inference error, sampled when start is accepted.
REQ-011 Port busy, output, 1: high in every state except IDLE.
REQ-012 Port done, output, 1: one-cycle pulse when the update completes.
REQ-013 Port mem_addr, output, IDX_W: shared address for the input and weight memories.
REQ-014 Port mem_re, output, 1: read strobe; the memories return data one cycle later.
REQ-015 Port in_data, input, I_PREC: input-vector read data.
REQ-016 Port w_rdata, input, W_PREC: weight read data.
REQ-017 Port mem_we, output, 1: weight write strobe.
REQ-018 Port w_wdata, output, W_PREC: updated weight to write.

Function
REQ-019 The FSM states are IDLE, READ, CALC, WRITE and DONE.
REQ-020 In IDLE with start=1, the block latches rate, error and idx=0, then moves to READ; if the latched error is all zeros it moves to DONE instead.
REQ-021 In READ, mem_re=1 and mem_addr=idx; the next state is CALC.
REQ-022 In CALC, in_data and w_rdata drive the datapath with the latched rate/error, and new_weight is registered into w_wdata; the next state is WRITE.
REQ-023 In WRITE, mem_we=1, mem_addr=idx and w_wdata holds the result; if idx==N_IN-1 the next state is DONE, otherwise idx increments and the next state is READ.
REQ-024 In DONE, done=1 for exactly one cycle; the next state is IDLE.
REQ-025 mem_re, mem_we and done are decoded from the state (Moore outputs); mem_re and mem_we are never high in the same cycle.
REQ-026 Latency: with start accepted at cycle 0, the write for index k occurs at cycle 3k+3 and done occurs at cycle 3*N_IN+1; when error is zero, done occurs at cycle 1 with no memory access.
REQ-027 start while busy=1 is ignored and not queued.
REQ-028 start held high through DONE is accepted again in the cycle after DONE, in IDLE.
REQ-029 Changes to rate or error while busy have no effect.
REQ-030 idx never exceeds N_IN-1; no wrap-around write to address 0 occurs.
REQ-031 Datapath overflow and underflow saturate inside the datapath, and the saturated value is written unchanged.

Reset
REQ-032 reset=1 immediately forces state=IDLE, idx=0, busy=0, done=0, mem_re=0, mem_we=0, mem_addr=0 and w_wdata=0, with rate and error latches also cleared to 0.
REQ-033 Reset in mid-operation aborts with no further write; weights already written keep their new values; no done pulse is produced.

Structure
REQ-034 The FSM state enum and the state encoding widths belong in the shared slp package.
REQ-035 One sub-module is instantiated: slp_calc_fp_weight, with all format parameters and ADALINE forwarded.
REQ-036 The datapath is purely combinational between the READ-data cycle and the w_wdata register; no additional pipeline stage is added.

Verification
REQ-037 N_IN=4, error nonzero, start pulsed at cycle 0 -> four writes at cycles 3, 6, 9, 12 to addresses 0..3, and done=1 only at cycle 13.
REQ-038 error=0 at start -> done at cycle 1; mem_re and mem_we stay 0 throughout.
REQ-039 Input memory all zeros, weights 16'h0100, error nonzero -> every write carries w_wdata=16'h0100.
REQ-040 start re-pulsed at cycles 2 and 5 of an active update -> ignored; exactly one done; write count equals N_IN.
REQ-041 reset asserted at cycle 7 of an N_IN=4 update -> outputs are zero immediately; addresses 0 and 1 hold updated weights, addresses 2 and 3 are unchanged; no done.
REQ-042 start held high continuously -> back-to-back updates with exactly one IDLE cycle between a DONE and the next READ.
